// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
// led_scan_pkg : shared constants and types for the LED scan capture block
// Revision 1.0 - initial release
// ============================================================================
package led_scan_pkg;

    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int ROW_MSB = 35;
    localparam int ROW_LSB = 32;
    localparam int GRN_MSB = 31;
    localparam int RED_MSB = 15;

    typedef logic [ROWS-1:0][COLS-1:0] pixel_frame_t;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        FILL = 1'b1
    } scan_state_t;

    // The bus carries column 0 in the field MSB; pixel rows index column 0 at bit 0.
    function automatic logic [COLS-1:0] col_order(input logic [COLS-1:0] field);
        logic [COLS-1:0] res;
        for (int c = 0; c < COLS; c++) begin
            res[c] = field[COLS-1-c];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_capture_sampler.sv
`default_nettype none
// ============================================================================
// gpio_row_sampler : synchronizes the scan bus and emits one latch per row visit
// Revision 1.0 - initial release
// ============================================================================
module gpio_row_sampler
    import led_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [35:0] GPIO_1,
    output logic        latch_evt,
    output logic [3:0]  latch_row,
    output logic [15:0] latch_grn,
    output logic [15:0] latch_red
);

    localparam int             CW         = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0]  SETTLE_CNT = CW'(SETTLE);

    logic [35:0]   s1;
    logic [35:0]   s2;
    logic [35:0]   prev;
    logic [CW-1:0] cnt;
    logic          latched;
    logic          stable;
    logic          row_change;

    assign stable     = (s2 == prev);
    assign row_change = (s2[ROW_MSB:ROW_LSB] != prev[ROW_MSB:ROW_LSB]);

    // The bus must still be stable on the latch edge itself, so a row held for
    // fewer than SETTLE+2 cycles is never captured.
    assign latch_evt  = (cnt == SETTLE_CNT) && !latched && stable;

    assign latch_row  = prev[ROW_MSB:ROW_LSB];
    assign latch_grn  = col_order(prev[GRN_MSB:GRN_MSB-15]);
    assign latch_red  = col_order(prev[RED_MSB:0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            cnt     <= '0;
            latched <= 1'b0;
        end else begin
            s1   <= GPIO_1;
            s2   <= s1;
            prev <= s2;

            if (stable) begin
                if (cnt != SETTLE_CNT) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end

            if (row_change) begin
                latched <= 1'b0;
            end else if (latch_evt) begin
                latched <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_scan_capture.sv
`default_nettype none
// ============================================================================
// led_scan_capture : rebuilds the 16x16 red/green frame from the scanned bus
// Revision 1.0 - initial release
// ============================================================================
module led_scan_capture
    import led_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [35:0]         GPIO_1,
    output logic [15:0][15:0]   RedPixels,
    output logic [15:0][15:0]   GrnPixels,
    output logic                FrameValid,
    output logic                FrameStrobe,
    output logic                SeqError,
    output logic [7:0]          FrameCount
);

    logic         latch_evt;
    logic [3:0]   latch_row;
    logic [15:0]  latch_grn;
    logic [15:0]  latch_red;

    scan_state_t  state;
    logic [3:0]   expected;
    pixel_frame_t work_red;
    pixel_frame_t work_grn;
    pixel_frame_t red_commit;
    pixel_frame_t grn_commit;

    gpio_row_sampler #(
        .SETTLE    (SETTLE)
    ) u_sampler (
        .CLK       (CLK),
        .RST       (RST),
        .GPIO_1    (GPIO_1),
        .latch_evt (latch_evt),
        .latch_row (latch_row),
        .latch_grn (latch_grn),
        .latch_red (latch_red)
    );

    // Row 15 is committed on the same edge it arrives, so it bypasses the buffer.
    always_comb begin
        red_commit         = work_red;
        grn_commit         = work_grn;
        red_commit[ROWS-1] = latch_red;
        grn_commit[ROWS-1] = latch_grn;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            expected    <= 4'd0;
            work_red    <= '0;
            work_grn    <= '0;
            RedPixels   <= '0;
            GrnPixels   <= '0;
            FrameValid  <= 1'b0;
            FrameStrobe <= 1'b0;
            SeqError    <= 1'b0;
            FrameCount  <= 8'd0;
        end else begin
            FrameStrobe <= 1'b0;
            SeqError    <= 1'b0;
            if (latch_evt) begin
                case (state)
                    HUNT: begin
                        if (latch_row == 4'd0) begin
                            work_red[0] <= latch_red;
                            work_grn[0] <= latch_grn;
                            expected    <= 4'd1;
                            state       <= FILL;
                        end
                    end
                    FILL: begin
                        if (latch_row == expected) begin
                            work_red[latch_row] <= latch_red;
                            work_grn[latch_row] <= latch_grn;
                            if (latch_row == 4'(ROWS - 1)) begin
                                RedPixels   <= red_commit;
                                GrnPixels   <= grn_commit;
                                FrameStrobe <= 1'b1;
                                FrameValid  <= 1'b1;
                                FrameCount  <= FrameCount + 8'd1;
                                state       <= HUNT;
                            end else begin
                                expected <= expected + 4'd1;
                            end
                        end else begin
                            SeqError <= 1'b1;
                            if (latch_row == 4'd0) begin
                                work_red[0] <= latch_red;
                                work_grn[0] <= latch_grn;
                                expected    <= 4'd1;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_capture.sv
`default_nettype none
// ============================================================================
// tb_led_scan_capture : directed frames checked against a row-level frame model
// Revision 1.0 - initial release
// ============================================================================
module tb_led_scan_capture;
    import led_scan_pkg::*;

    localparam int SETTLE = 2;
    localparam logic [35:0] IDLE = {4'hF, 32'h0};

    logic              CLK = 1'b0;
    logic              RST;
    logic [35:0]       GPIO_1;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              FrameValid;
    logic              FrameStrobe;
    logic              SeqError;
    logic [7:0]        FrameCount;

    led_scan_capture #(.SETTLE(SETTLE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .GPIO_1      (GPIO_1),
        .RedPixels   (RedPixels),
        .GrnPixels   (GrnPixels),
        .FrameValid  (FrameValid),
        .FrameStrobe (FrameStrobe),
        .SeqError    (SeqError),
        .FrameCount  (FrameCount)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- frame model: rows arrive as events, frames complete in order
    typedef struct {
        int          t;
        logic [3:0]  row;
        logic [15:0] grn;
        logic [15:0] red;
    } ev_t;

    ev_t         evq[$];
    int          last_row;
    bit          visit_done;
    bit          hunting;
    int          expect_row;
    logic [15:0] m_wred[16];
    logic [15:0] m_wgrn[16];
    logic [15:0] m_ored[16];
    logic [15:0] m_ogrn[16];
    bit          m_valid;
    int          m_count;
    int          strobe_t;
    int          err_t;
    bit          chk_en = 1'b0;
    int          strobe_seen = 0;
    int          err_seen = 0;
    int          strobe_cyc = -1;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic model_reset();
        evq.delete();
        last_row   = -1;
        visit_done = 1'b0;
        hunting    = 1'b1;
        expect_row = 0;
        for (int i = 0; i < 16; i++) begin
            m_wred[i] = '0; m_wgrn[i] = '0; m_ored[i] = '0; m_ogrn[i] = '0;
        end
        m_valid  = 1'b0;
        m_count  = 0;
        strobe_t = -1;
        err_t    = -1;
    endtask

    task automatic model_apply(input ev_t e);
        int r;
        r = int'(e.row);
        if (hunting) begin
            if (r == 0) begin
                m_wred[0] = rev16(e.red); m_wgrn[0] = rev16(e.grn);
                expect_row = 1; hunting = 1'b0;
            end
        end else if (r == expect_row) begin
            m_wred[r] = rev16(e.red); m_wgrn[r] = rev16(e.grn);
            if (r == 15) begin
                for (int i = 0; i < 16; i++) begin
                    m_ored[i] = m_wred[i]; m_ogrn[i] = m_wgrn[i];
                end
                m_valid  = 1'b1;
                m_count  = (m_count + 1) % 256;
                strobe_t = e.t;
                hunting  = 1'b1;
            end else begin
                expect_row++;
            end
        end else begin
            err_t = e.t;
            if (r == 0) begin
                m_wred[0] = rev16(e.red); m_wgrn[0] = rev16(e.grn);
                expect_row = 1;
            end else begin
                hunting = 1'b1;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [15:0][15:0] er;
            logic [15:0][15:0] eg;
            ev_t e;
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                e = evq.pop_front();
                model_apply(e);
            end
            for (int r = 0; r < 16; r++) begin
                er[r] = m_ored[r];
                eg[r] = m_ogrn[r];
            end
            check("red_frame",   RedPixels, er);
            check("grn_frame",   GrnPixels, eg);
            check("frame_valid", 256'(FrameValid), 256'(m_valid));
            check("frame_count", 256'(FrameCount), 256'(m_count[7:0]));
            check("strobe",      256'(FrameStrobe), 256'(strobe_t == cyc));
            check("seq_error",   256'(SeqError), 256'(err_t == cyc));
            if (FrameStrobe === 1'b1) begin
                strobe_seen++;
                strobe_cyc = cyc;
            end
            if (SeqError === 1'b1) err_seen++;
        end
    end

    // Called #1 after an edge; the next edge is the first to sample this value.
    task automatic drive_row(input int row, input logic [15:0] grn, input logic [15:0] red, input int hold);
        ev_t e;
        GPIO_1 = {row[3:0], grn, red};
        if (row != last_row) visit_done = 1'b0;
        if (!visit_done && hold >= SETTLE + 2) begin
            e.t = cyc + 1 + SETTLE + 3; e.row = row[3:0]; e.grn = grn; e.red = red;
            evq.push_back(e);
            visit_done = 1'b1;
        end
        last_row = row;
        repeat (hold) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] pat_g(input int seed, input int r);
        return 16'((seed + 1) * (r + 3) * 257);
    endfunction

    function automatic logic [15:0] pat_r(input int seed, input int r);
        return 16'(seed * 977 + r * 131 + 5);
    endfunction

    task automatic clean_frame(input int seed);
        for (int r = 0; r < 16; r++) drive_row(r, pat_g(seed, r), pat_r(seed, r), 8);
        drive_row(15, 16'h0, 16'h0, 12);
    endtask

    initial begin
        int c15;
        int s0;
        int e0;
        logic [15:0][15:0] lit;
        RST    = 1'b1;
        GPIO_1 = IDLE;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        chk_en = 1'b1;

        check("reset_count", 256'(FrameCount), 256'(0));
        check("reset_valid", 256'(FrameValid), 256'(0));

        // 1: diagonal red frame
        for (int r = 0; r < 16; r++) begin
            if (r == 15) c15 = cyc + 1;
            drive_row(r, 16'h0, 16'h8000 >> r, 8);
        end
        drive_row(15, 16'h0, 16'h0, 12);
        for (int r = 0; r < 16; r++) check("diag_red_row", 256'(RedPixels[r]), 256'(16'h0001 << r));
        check("diag_grn",     GrnPixels, 256'(0));
        check("diag_valid",   256'(FrameValid), 256'(1));
        check("diag_count",   256'(FrameCount), 256'(1));
        check("diag_strobes", 256'(strobe_seen), 256'(1));
        check("diag_latency", 256'(strobe_cyc), 256'(c15 + SETTLE + 3));
        check("diag_errors",  256'(err_seen), 256'(0));

        // 2: bit order
        for (int r = 0; r < 16; r++) begin
            if (r == 3) drive_row(r, 16'h8000, 16'h0001, 8);
            else        drive_row(r, 16'h0, 16'h0, 8);
        end
        drive_row(15, 16'h0, 16'h0, 12);
        lit = '0;
        lit[3] = 16'h0001;
        check("order_grn", GrnPixels, lit);
        lit[3] = 16'h8000;
        check("order_red", RedPixels, lit);
        check("order_count", 256'(FrameCount), 256'(2));

        // 3: short hold on row 6
        do_reset();
        check("rst3_count", 256'(FrameCount), 256'(0));
        check("rst3_red",   RedPixels, 256'(0));
        s0 = strobe_seen; e0 = err_seen;
        for (int r = 0; r < 16; r++) drive_row(r, pat_g(7, r), pat_r(7, r), (r == 6) ? 3 : 8);
        drive_row(15, 16'h0, 16'h0, 12);
        check("short_strobes", 256'(strobe_seen - s0), 256'(0));
        check("short_errors",  256'(err_seen - e0), 256'(1));
        clean_frame(1);
        check("short_next_count", 256'(FrameCount), 256'(1));
        check("short_next_red0",  256'(RedPixels[0]), 256'(rev16(pat_r(1, 0))));

        // 4: skipped row
        s0 = strobe_seen; e0 = err_seen;
        for (int r = 0; r < 8; r++) drive_row(r, 16'hFFFF, 16'hFFFF, 8);
        drive_row(9, 16'hFFFF, 16'hFFFF, 8);
        for (int r = 12; r < 16; r++) drive_row(r, 16'hFFFF, 16'hFFFF, 8);
        drive_row(15, 16'h0, 16'h0, 12);
        check("skip_errors",  256'(err_seen - e0), 256'(1));
        check("skip_strobes", 256'(strobe_seen - s0), 256'(0));
        check("skip_kept_grn5", 256'(GrnPixels[5]), 256'(rev16(pat_g(1, 5))));
        clean_frame(2);
        check("skip_next_count", 256'(FrameCount), 256'(2));

        // 5: stalled scan on row 5
        e0 = err_seen;
        for (int r = 0; r < 5; r++) drive_row(r, 16'h0, 16'h0, 8);
        drive_row(5, 16'hFFFF, 16'h0, 22);
        drive_row(5, 16'h0000, 16'h0, 178);
        for (int r = 6; r < 16; r++) drive_row(r, 16'h0, 16'h0, 8);
        drive_row(15, 16'h0, 16'h0, 12);
        check("stall_grn5",   256'(GrnPixels[5]), 256'(16'hFFFF));
        check("stall_grn4",   256'(GrnPixels[4]), 256'(0));
        check("stall_count",  256'(FrameCount), 256'(3));
        check("stall_errors", 256'(err_seen - e0), 256'(0));

        // 6: reset while row 10 is on the bus
        for (int r = 0; r < 10; r++) drive_row(r, pat_g(4, r), pat_r(4, r), 8);
        drive_row(10, pat_g(4, 10), pat_r(4, 10), 4);
        do_reset();
        check("rst6_red",    RedPixels, 256'(0));
        check("rst6_grn",    GrnPixels, 256'(0));
        check("rst6_valid",  256'(FrameValid), 256'(0));
        check("rst6_count",  256'(FrameCount), 256'(0));
        s0 = strobe_seen; e0 = err_seen;
        for (int r = 11; r < 16; r++) drive_row(r, 16'h1111, 16'h2222, 8);
        drive_row(15, 16'h0, 16'h0, 12);
        check("resume_errors",  256'(err_seen - e0), 256'(0));
        check("resume_strobes", 256'(strobe_seen - s0), 256'(0));
        clean_frame(3);
        check("resume_count", 256'(FrameCount), 256'(1));
        check("resume_grn15", 256'(GrnPixels[15]), 256'(rev16(pat_g(3, 15))));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
